// File: rtl/uriscv_irq_ctrl.sv
// rtl/uriscv_irq_ctrl.sv - platform interrupt controller feeding the core MEIP input
// Synchronises sources, latches pending, fixed-priority select, claim/complete register port.
module uriscv_irq_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o
);

  localparam logic [3:0] A_ENABLE  = 4'h0;
  localparam logic [3:0] A_PENDING = 4'h4;
  localparam logic [3:0] A_CLAIM   = 4'h8;
  localparam logic [3:0] A_VBASE   = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] edge_pend_q, enable_q, in_service_q, best_oh_q;
  logic [4:0]         best_id_q, claimed_id_q;
  logic [31:0]        vbase_q, rdata_q, isr_vector_q;
  logic               ack_q, intr_q;

  logic [NUM_SRC-1:0] pending, cand, best_oh_d, pend_w1c, claim_clr, edge_rise;
  logic [4:0]         best_id_d;
  logic [31:0]        rd_val;
  logic               rd_acc, wr_acc, cand_best, claim_go, complete;

  // Level bits are live synced lines, masked while their ID is in service.
  assign pending   = (edge_pend_q & EDGE_MASK) | (sync2_q & ~EDGE_MASK & ~in_service_q);
  assign cand      = pending & enable_q & ~in_service_q;
  assign cand_best = |(cand & best_oh_q);
  assign edge_rise = sync2_q & ~sync3_q;

  assign rd_acc   = req_i & ~we_i;
  assign wr_acc   = req_i & we_i;
  assign claim_go = rd_acc && (addr_i == A_CLAIM) && (state_q == S_REQ) && cand_best;
  assign complete = wr_acc && (addr_i == A_CLAIM) && (state_q == S_BUSY) &&
                    (wdata_i[4:0] == claimed_id_q);
  assign pend_w1c  = (wr_acc && addr_i == A_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;
  assign claim_clr = claim_go ? best_oh_q : '0;

  // Scan high to low so the lowest index is the last assignment and wins.
  always_comb begin
    best_id_d = '0;
    best_oh_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        best_id_d = 5'(i + 1);
        best_oh_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << i;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i)
      A_ENABLE:  rd_val = 32'(enable_q);
      A_PENDING: rd_val = 32'(pending);
      A_CLAIM:   rd_val = claim_go ? 32'(best_id_q) : 32'h0;
      A_VBASE:   rd_val = vbase_q;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      edge_pend_q <= '0;
      best_id_q   <= '0;
      best_oh_q   <= '0;
    end else begin
      sync1_q     <= irq_src_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      // A fresh rise beats a same-cycle claim or W1C clear.
      edge_pend_q <= ((edge_pend_q & ~pend_w1c & ~claim_clr) | edge_rise) & EDGE_MASK;
      best_id_q   <= best_id_d;
      best_oh_q   <= best_oh_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      vbase_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q   <= req_i;
      rdata_q <= rd_acc ? rd_val : 32'h0;
      if (wr_acc && addr_i == A_ENABLE) enable_q <= wdata_i[NUM_SRC-1:0];
      if (wr_acc && addr_i == A_VBASE)  vbase_q  <= {wdata_i[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      intr_q       <= 1'b0;
      in_service_q <= '0;
      claimed_id_q <= '0;
      isr_vector_q <= '0;
    end else begin
      if (state_q != S_BUSY)
        isr_vector_q <= vbase_q + {25'b0, best_id_q, 2'b00};
      case (state_q)
        S_IDLE: begin
          if (best_id_q != 5'd0 && cand_best) begin
            state_q <= S_REQ;
            intr_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (claim_go) begin
            state_q      <= S_BUSY;
            intr_q       <= 1'b0;
            in_service_q <= best_oh_q;
            claimed_id_q <= best_id_q;
          end else if (cand == '0) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (complete) begin
            state_q      <= S_IDLE;
            in_service_q <= '0;
            claimed_id_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o      = rdata_q;
  assign ack_o        = ack_q;
  assign intr_o       = intr_q;
  assign isr_vector_o = isr_vector_q;

endmodule
